// File: rtl/unidade_hilo.sv
//------------------------------------------------------------------------------
// Module      : unidade_hilo
// Description : Iterative multiply/divide unit owning the HI/LO register pair.
//               Define HILO_EARLY_OUT_EN for early multiply termination.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module unidade_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       ulaOP,
    input  logic [WIDTH-1:0] RS,
    input  logic [WIDTH-1:0] RT,
    input  logic             escreveHI,
    input  logic             escreveLO,
    input  logic             leSel,
    output logic             ocupado,
    output logic             pronto,
    output logic             divZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] saidaHILO
);

    localparam int         c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [4:0] c_OP_MULT  = 5'b00010;
    localparam logic [4:0] c_OP_DIV   = 5'b00011;
    localparam logic [4:0] c_OP_REM   = 5'b00100;
    localparam logic [1:0] c_OCIOSO   = 2'd0;
    localparam logic [1:0] c_MULT     = 2'd1;
    localparam logic [1:0] c_DIV      = 2'd2;
    localparam logic [1:0] c_FIM      = 2'd3;

    logic [1:0]         state_q,   state_d;
    logic [c_CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               pronto_q,  pronto_d;
    logic               divzero_q, divzero_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [2*WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [WIDTH-1:0]   rem_q,     rem_d;
    logic [WIDTH-1:0]   quo_q,     quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;

    logic               w_op_valid;
    logic               w_idle;
    logic               w_accept;
    logic               w_last;
    logic               w_mult_done;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    assign w_op_valid = (ulaOP == c_OP_MULT) || (ulaOP == c_OP_DIV) || (ulaOP == c_OP_REM);
    assign w_idle     = (state_q == c_OCIOSO) || (state_q == c_FIM);
    assign w_accept   = start && w_op_valid && w_idle;
    assign w_last     = (cnt_q == c_CNT_W'(WIDTH - 1));

    // Multiplicand shifts left so the accumulator is always the exact partial product
    assign w_acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign w_mplier_next = mplier_q >> 1;

`ifdef HILO_EARLY_OUT_EN
    assign w_mult_done = w_last || (w_mplier_next == '0);
`else
    assign w_mult_done = w_last;
`endif

    // Restoring step: the low WIDTH bits of the difference are exact whenever it fits
    assign w_shift    = {rem_q, quo_q[WIDTH-1]};
    assign w_fits     = (w_shift >= {1'b0, divisor_q});
    assign w_diff     = w_shift[WIDTH-1:0] - divisor_q;
    assign w_rem_next = w_fits ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_next = {quo_q[WIDTH-2:0], w_fits};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pronto_d  = 1'b0;
        divzero_d = 1'b0;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;

        if (w_idle) begin
            if (escreveHI) hi_d = RS;
            if (escreveLO) lo_d = RS;
        end

        case (state_q)
            c_OCIOSO, c_FIM: begin
                state_d = c_OCIOSO;
                if (w_accept) begin
                    cnt_d     = '0;
                    acc_d     = '0;
                    mcand_d   = {{WIDTH{1'b0}}, RS};
                    mplier_d  = RT;
                    rem_d     = '0;
                    quo_d     = RS;
                    divisor_d = RT;
                    state_d   = (ulaOP == c_OP_MULT) ? c_MULT : c_DIV;
                end
            end
            c_MULT: begin
                acc_d    = w_acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = w_mplier_next;
                cnt_d    = cnt_q + c_CNT_W'(1);
                if (w_mult_done) begin
                    hi_d     = w_acc_next[2*WIDTH-1:WIDTH];
                    lo_d     = w_acc_next[WIDTH-1:0];
                    pronto_d = 1'b1;
                    state_d  = c_FIM;
                end
            end
            c_DIV: begin
                if (divisor_q == '0) begin
                    hi_d      = quo_q;
                    lo_d      = '1;
                    pronto_d  = 1'b1;
                    divzero_d = 1'b1;
                    state_d   = c_FIM;
                end else begin
                    rem_d = w_rem_next;
                    quo_d = w_quo_next;
                    cnt_d = cnt_q + c_CNT_W'(1);
                    if (w_last) begin
                        hi_d     = w_rem_next;
                        lo_d     = w_quo_next;
                        pronto_d = 1'b1;
                        state_d  = c_FIM;
                    end
                end
            end
            default: state_d = c_OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= c_OCIOSO;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pronto_q  <= 1'b0;
            divzero_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pronto_q  <= pronto_d;
            divzero_q <= divzero_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
        end
    end

    assign ocupado   = (state_q == c_MULT) || (state_q == c_DIV);
    assign pronto    = pronto_q;
    assign divZero   = divzero_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign saidaHILO = leSel ? hi_q : lo_q;

endmodule

`default_nettype wire

// File: tb/tb_unidade_hilo.sv
//------------------------------------------------------------------------------
// Module      : tb_unidade_hilo
// Description : Self-checking bench for unidade_hilo against an arithmetic model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_unidade_hilo;

    localparam int         W         = 32;
    localparam logic [4:0] c_OP_MULT = 5'b00010;
    localparam logic [4:0] c_OP_DIV  = 5'b00011;
    localparam logic [4:0] c_OP_REM  = 5'b00100;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [4:0]   ula_op;
    logic [W-1:0] rs, rt;
    logic         escreve_hi, escreve_lo, le_sel;
    logic         ocupado, pronto, div_zero;
    logic [W-1:0] hi, lo, saida;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] hi_m, lo_m;

    always #5 clk = ~clk;

    unidade_hilo #(.WIDTH(W)) dut (
        .clock     (clk),
        .reset     (rst),
        .start     (start),
        .ulaOP     (ula_op),
        .RS        (rs),
        .RT        (rt),
        .escreveHI (escreve_hi),
        .escreveLO (escreve_lo),
        .leSel     (le_sel),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .divZero   (div_zero),
        .HI        (hi),
        .LO        (lo),
        .saidaHILO (saida)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges from acceptance until the result is written
    function automatic int exp_lat(input logic [4:0] op, input logic [W-1:0] b);
        if (op != c_OP_MULT) return (b == '0) ? 1 : W;
`ifdef HILO_EARLY_OUT_EN
        for (int i = W - 1; i >= 0; i--)
            if (b[i]) return i + 1;
        return 1;
`else
        return W;
`endif
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 1;
            2:       return '1;
            3:       return W'($urandom_range(1, 255));
            default: return W'($urandom);
        endcase
    endfunction

    // Issues a start in the current cycle and stays in the FIM cycle on return
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb);
        logic [63:0]  prod;
        logic [W-1:0] eh, el;
        logic         dz;
        int           lat, n;
        if (op == c_OP_MULT) begin
            prod = 64'(a) * 64'(b);
            eh = prod[63:32]; el = prod[31:0]; dz = 1'b0;
        end else if (b == '0) begin
            eh = a; el = '1; dz = 1'b1;
        end else begin
            eh = a % b; el = a / b; dz = 1'b0;
        end
        lat = exp_lat(op, b);
        start = 1'b1; ula_op = op; rs = a; rt = b;
        tick();
        start = 1'b0; rs = W'($urandom); rt = W'($urandom);
        check("busy_after_start", ocupado, 1);
        check("pronto_after_start", pronto, 0);
        n = 0;
        while (!pronto && n < 200) begin
            if (disturb && n == 3) begin
                start = 1'b1; ula_op = c_OP_DIV; rs = 9; escreve_hi = 1'b1;
            end
            tick();
            start = 1'b0; escreve_hi = 1'b0;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("pronto", pronto, 1);
        check("busy_in_fim", ocupado, 0);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("div_zero", div_zero, dz);
        le_sel = $urandom_range(0, 1);
        #1;
        check("saida", saida, le_sel ? eh : el);
        hi_m = eh; lo_m = el;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit        saw_pronto;
        logic [4:0] op;
        logic [W-1:0] v;

        rst = 1'b1; start = 1'b0; ula_op = '0; rs = '0; rt = '0;
        escreve_hi = 1'b0; escreve_lo = 1'b0; le_sel = 1'b0;
        tick(); tick();
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_divzero", div_zero, 0);
        check("rst_saida", saida, 0);
        rst = 1'b0;
        hi_m = '0; lo_m = '0;

        // Reset in the middle of a multiply
        start = 1'b1; ula_op = c_OP_MULT; rs = 7; rt = 6;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", ocupado, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_pronto", pronto, 0);
        saw_pronto = 1'b0;
        repeat (40) begin
            tick();
            if (pronto || ocupado) saw_pronto = 1'b1;
        end
        check("midrst_quiet", saw_pronto, 0);

        // Directed cases, chained back-to-back through the FIM cycle
        run_op(c_OP_MULT, '1, '1, 1'b0);
        run_op(c_OP_MULT, 32'd12345, 32'd2, 1'b0);
        run_op(c_OP_DIV, 32'd100, 32'd7, 1'b0);
        le_sel = 1'b1; #1;
        check("div_rem_read", saida, 2);
        le_sel = 1'b0; #1;
        check("div_quo_read", saida, 14);
        run_op(c_OP_DIV, 32'd55, 32'd0, 1'b0);
        run_op(c_OP_REM, 32'd1000, 32'd3, 1'b1);
        run_op(c_OP_MULT, 32'hDEADBEEF, 32'h1234, 1'b1);

        tick();
        check("fim_to_idle_pronto", pronto, 0);
        check("fim_to_idle_divzero", div_zero, 0);

        // Unrecognised codes never start anything
        start = 1'b1; ula_op = 5'b00000;
        tick();
        ula_op = 5'b00101;
        tick();
        start = 1'b0;
        check("bad_op_busy", ocupado, 0);
        check("bad_op_pronto", pronto, 0);

        escreve_lo = 1'b1; rs = 5;
        tick();
        escreve_lo = 1'b0;
        lo_m = 5;
        check("mtlo", lo, lo_m);
        check("mtlo_hi_kept", hi, hi_m);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 3))
                0:       op = c_OP_DIV;
                1:       op = c_OP_REM;
                default: op = c_OP_MULT;
            endcase
            run_op(op, pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                tick();
                v = W'($urandom);
                rs = v;
                if ($urandom_range(0, 1) == 1) begin
                    escreve_hi = 1'b1; hi_m = v;
                end else begin
                    escreve_lo = 1'b1; lo_m = v;
                end
                tick();
                escreve_hi = 1'b0; escreve_lo = 1'b0;
                check("rand_mthi", hi, hi_m);
                check("rand_mtlo", lo, lo_m);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
